// File: rtl/downlink_pkg.sv
// Shared state encoding and default timing constants for the envelope downlink decoder.
package downlink_pkg;

  typedef enum logic [2:0] {
    StDisabled,
    StIdle,
    StDelim,
    StDataHigh,
    StDataLow
  } dl_state_e;

  localparam int unsigned DefGlitchLen = 2;
  localparam int unsigned DefDelimMin  = 20;
  localparam int unsigned DefDelimMax  = 40;
  localparam int unsigned DefBitThresh = 30;
  localparam int unsigned DefTimeout   = 100;
  localparam int unsigned SegCntW      = 16;

  function automatic logic state_is_busy(dl_state_e s);
    return (s == StDelim) || (s == StDataHigh) || (s == StDataLow);
  endfunction

endpackage

// File: rtl/env_glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter on the raw envelope comparator.
module env_glitch_filter
  import downlink_pkg::*;
#(
  parameter int unsigned GLITCH_LEN = DefGlitchLen
) (
  input  logic clock,
  input  logic reset,
  input  logic env_i,
  output logic env_f_o
);

  localparam int unsigned CntW = (GLITCH_LEN < 2) ? 1 : $clog2(GLITCH_LEN);

  logic            sync1_q, sync2_q;
  logic            env_f_q, env_f_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive cycles the synchronized level has disagreed with env_f.
  always_comb begin
    env_f_d = env_f_q;
    cnt_d   = '0;
    if (sync2_q != env_f_q) begin
      if (cnt_q == CntW'(GLITCH_LEN - 1)) begin
        env_f_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      env_f_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= env_i;
      sync2_q <= sync1_q;
      env_f_q <= env_f_d;
      cnt_q   <= cnt_d;
    end
  end

  assign env_f_o = env_f_q;

endmodule

// File: rtl/envelope_downlink_decoder.sv
// Pulse-width downlink decoder: delimiter detection, bit slicing by high length, byte assembly.
module envelope_downlink_decoder
  import downlink_pkg::*;
#(
  parameter int unsigned GLITCH_LEN = DefGlitchLen,
  parameter int unsigned DELIM_MIN  = DefDelimMin,
  parameter int unsigned DELIM_MAX  = DefDelimMax,
  parameter int unsigned BIT_THRESH = DefBitThresh,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       env_in,
  output logic       envelop_detector_enable,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_done,
  output logic       frame_error,
  output logic [2:0] partial_bits,
  output logic       busy
);

  localparam logic [SegCntW-1:0] DelimMinC  = SegCntW'(DELIM_MIN);
  localparam logic [SegCntW-1:0] DelimMaxC  = SegCntW'(DELIM_MAX);
  localparam logic [SegCntW-1:0] BitThreshC = SegCntW'(BIT_THRESH);
  localparam logic [SegCntW-1:0] TimeoutC   = SegCntW'(TIMEOUT);

  logic env_f, env_prev_q;
  logic rise, fall, edge_seen;

  env_glitch_filter #(
    .GLITCH_LEN(GLITCH_LEN)
  ) u_filter (
    .clock  (clock),
    .reset  (reset),
    .env_i  (env_in),
    .env_f_o(env_f)
  );

  assign rise      = env_f & ~env_prev_q;
  assign fall      = ~env_f & env_prev_q;
  assign edge_seen = rise | fall;

  // On an edge cycle seg_cnt_q still holds the length of the segment that just ended.
  logic [SegCntW-1:0] seg_cnt_q, seg_cnt_d;

  always_comb begin
    if (edge_seen) begin
      seg_cnt_d = SegCntW'(1);
    end else if (&seg_cnt_q) begin
      seg_cnt_d = seg_cnt_q;
    end else begin
      seg_cnt_d = seg_cnt_q + 1'b1;
    end
  end

  dl_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       any_bit_q, any_bit_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [2:0] partial_q, partial_d;
  logic       busy_q, en_q;
  logic       bit_val;
  logic       delim_ok, low_too_long;

  assign bit_val      = (seg_cnt_q >= BitThreshC);
  assign delim_ok     = (seg_cnt_q >= DelimMinC) && (seg_cnt_q <= DelimMaxC);
  assign low_too_long = (seg_cnt_q > DelimMaxC);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    any_bit_d  = any_bit_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    partial_d  = 3'd0;

    if (!enable) begin
      state_d = StDisabled;
    end else begin
      unique case (state_q)
        StDisabled: begin
          if (env_f) state_d = StIdle;
        end
        StIdle: begin
          if (fall) state_d = StDelim;
        end
        StDelim: begin
          // A high level without a qualifying rise (re-entry after an abort) is never a delimiter.
          if (rise) begin
            state_d = delim_ok ? StDataHigh : StIdle;
          end else if (env_f || low_too_long) begin
            state_d = StIdle;
          end
        end
        StDataHigh: begin
          if (fall) begin
            shift_d   = {shift_q[6:0], bit_val};
            bit_cnt_d = bit_cnt_q + 3'd1;
            any_bit_d = 1'b1;
            state_d   = StDataLow;
            if (bit_cnt_q == 3'd7) begin
              rx_byte_d  = {shift_q[6:0], bit_val};
              rx_valid_d = 1'b1;
            end
          end else if (seg_cnt_q >= TimeoutC) begin
            if (any_bit_q) begin
              done_d    = 1'b1;
              partial_d = bit_cnt_q;
            end
            state_d = StIdle;
          end
        end
        StDataLow: begin
          if (low_too_long) begin
            err_d     = 1'b1;
            partial_d = bit_cnt_q;
            state_d   = StDelim;
          end else if (rise) begin
            state_d = StDataHigh;
          end
        end
        default: state_d = StDisabled;
      endcase
    end

    // Any frame boundary discards the unfinished byte.
    if ((state_d == StDisabled) || (state_d == StIdle) || (state_d == StDelim)) begin
      shift_d   = 8'd0;
      bit_cnt_d = 3'd0;
      any_bit_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      env_prev_q <= 1'b1;
      seg_cnt_q  <= '0;
      state_q    <= StDisabled;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      any_bit_q  <= 1'b0;
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      partial_q  <= 3'd0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      env_prev_q <= env_f;
      seg_cnt_q  <= seg_cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      any_bit_q  <= any_bit_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      partial_q  <= partial_d;
      busy_q     <= state_is_busy(state_d);
      en_q       <= enable;
    end
  end

  assign envelop_detector_enable = en_q;
  assign rx_byte                 = rx_byte_q;
  assign rx_byte_valid           = rx_valid_q;
  assign frame_done              = done_q;
  assign frame_error             = err_q;
  assign partial_bits            = partial_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_envelope_downlink_decoder.sv
// Scoreboard bench: a segment-level reference model predicts decoder events from pulse lengths.
module tb_envelope_downlink_decoder;

  localparam int DMin = 20;
  localparam int DMax = 40;
  localparam int Thr  = 30;
  localparam int Tout = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       env_in = 1'b1;
  logic       envelop_detector_enable;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, frame_done, frame_error, busy;
  logic [2:0] partial_bits;

  always #5 clock = ~clock;

  envelope_downlink_decoder #(
    .GLITCH_LEN(2),
    .DELIM_MIN (DMin),
    .DELIM_MAX (DMax),
    .BIT_THRESH(Thr),
    .TIMEOUT   (Tout)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable                 (enable),
    .env_in                 (env_in),
    .envelop_detector_enable(envelop_detector_enable),
    .rx_byte                (rx_byte),
    .rx_byte_valid          (rx_byte_valid),
    .frame_done             (frame_done),
    .frame_error            (frame_error),
    .partial_bits           (partial_bits),
    .busy                   (busy)
  );

  // kind: 0 = byte, 1 = frame done, 2 = frame error
  typedef struct {
    int kind;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: 0 = waiting for a delimiter, 1 = expecting a bit high, 2 = expecting a gap.
  int         m_phase = 0;
  int         m_nbits = 0;
  int         m_total = 0;
  logic [7:0] m_byte  = 8'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int k, input int d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_nbits = 0;
    m_total = 0;
    m_byte  = 8'd0;
  endfunction

  function automatic void model_seg(input logic lvl, input int len);
    if (m_phase == 0) begin
      if (!lvl && len >= DMin && len <= DMax) begin
        m_phase = 1;
        m_nbits = 0;
        m_total = 0;
      end
    end else if (m_phase == 1) begin
      if (len > Tout) begin
        if (m_total > 0) push_ev(1, m_nbits);
        m_phase = 0;
      end else begin
        m_byte  = {m_byte[6:0], (len >= Thr)};
        m_nbits = (m_nbits + 1) % 8;
        m_total++;
        if (m_nbits == 0) push_ev(0, int'(m_byte));
        m_phase = 2;
      end
    end else begin
      if (len > DMax) begin
        push_ev(2, m_nbits);
        m_phase = 0;
      end else begin
        m_phase = 1;
      end
    end
  endfunction

  task automatic drive_seg(input logic lvl, input int len, input bit gl);
    int gpos;
    gpos = (gl && len >= 8) ? int'($urandom_range(len - 4, 3)) : -1;
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      env_in = (i == gpos) ? ~lvl : lvl;
    end
  endtask

  task automatic send(input logic lvl, input int len, input bit gl);
    model_seg(lvl, len);
    drive_seg(lvl, len, gl);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit gl);
    for (int i = n - 1; i >= 0; i--) begin
      send(1'b1, bits[i] ? 35 : 20, gl);
      send(1'b0, 10, gl);
    end
  endtask

  task automatic rand_frame(input bit gl);
    int r, n;
    r = $urandom_range(7, 0);
    if (r == 0) send(1'b0, $urandom_range(19, 5), gl);
    else if (r == 1) send(1'b0, $urandom_range(60, 41), gl);
    else send(1'b0, $urandom_range(40, 20), gl);
    n = $urandom_range(19, 0);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1, 0) == 1) send(1'b1, $urandom_range(100, 30), gl);
      else send(1'b1, $urandom_range(29, 4), gl);
      if ($urandom_range(11, 0) == 0) send(1'b0, $urandom_range(55, 41), gl);
      else send(1'b0, $urandom_range(40, 4), gl);
    end
    send(1'b1, $urandom_range(140, 101), gl);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
    check(name, exp_q.size(), 0);
  endtask

  task automatic pop_cmp(input int kind, input int data, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_data"}, data, e.data);
    end
  endtask

  // Monitor: compares every presented pulse against the head of the expected queue.
  always @(negedge clock) begin
    if (reset) begin
      if (frame_done && frame_error) check("done_error_together", 1, 0);
      if (!frame_done && !frame_error) check("partial_bits_idle", int'(partial_bits), 0);
      if (rx_byte_valid) pop_cmp(0, int'(rx_byte), "rx_byte");
      if (frame_done) pop_cmp(1, int'(partial_bits), "frame_done");
      if (frame_error) pop_cmp(2, int'(partial_bits), "frame_error");
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_byte"}, int'(rx_byte), 0);
    check({tag, "_rx_valid"}, int'(rx_byte_valid), 0);
    check({tag, "_done"}, int'(frame_done), 0);
    check({tag, "_error"}, int'(frame_error), 0);
    check({tag, "_partial"}, int'(partial_bits), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_det_en"}, int'(envelop_detector_enable), 0);
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    send(1'b1, 12, 1'b0);
    check("det_en_on", int'(envelop_detector_enable), 1);
    check("idle_busy", int'(busy), 0);

    // 0xA5 reference frame
    send(1'b0, 30, 1'b0);
    send(1'b1, 35, 1'b0);
    check("busy_in_frame", int'(busy), 1);
    send(1'b0, 10, 1'b0);
    send_bits(32'h25, 7, 1'b0);
    send(1'b1, 150, 1'b0);
    wait_drain("drain_a5");
    check("busy_after_frame", int'(busy), 0);

    // Short delimiter is ignored
    send(1'b0, 10, 1'b0);
    send(1'b1, 150, 1'b0);
    check("short_delim_busy", int'(busy), 0);

    // 11 bits then timeout
    send(1'b0, 30, 1'b0);
    send_bits(32'h5A3, 11, 1'b0);
    send(1'b1, 150, 1'b0);
    wait_drain("drain_11bits");

    // Mid-frame long low aborts; a fresh delimiter decodes
    send(1'b0, 30, 1'b0);
    send_bits(32'h5, 3, 1'b0);
    send(1'b1, 20, 1'b0);
    send(1'b0, 50, 1'b0);
    send(1'b1, 20, 1'b0);
    send(1'b0, 25, 1'b0);
    send_bits(32'h3C, 8, 1'b0);
    send(1'b1, 150, 1'b0);
    wait_drain("drain_abort");

    // Glitched copy of the reference frame
    send(1'b0, 30, 1'b1);
    send_bits(32'hA5, 8, 1'b1);
    send(1'b1, 150, 1'b1);
    wait_drain("drain_glitch");

    // Timing boundaries
    send(1'b0, 19, 1'b0);
    send(1'b1, 20, 1'b0);
    send(1'b0, 41, 1'b0);
    send(1'b1, 20, 1'b0);
    send(1'b0, 20, 1'b0);
    send(1'b1, 29, 1'b0);
    send(1'b0, 40, 1'b0);
    send(1'b1, 30, 1'b0);
    send(1'b0, 41, 1'b0);
    send(1'b1, 30, 1'b0);
    send(1'b0, 40, 1'b0);
    send(1'b1, 100, 1'b0);
    send(1'b0, 4, 1'b0);
    send(1'b1, 101, 1'b0);
    wait_drain("drain_bounds");

    for (int f = 0; f < 30; f++) rand_frame($urandom_range(1, 0) == 1);
    wait_drain("drain_random");

    // Enable dropped mid-byte: no pulses, then a clean frame
    drive_seg(1'b0, 30, 1'b0);
    drive_seg(1'b1, 35, 1'b0);
    drive_seg(1'b0, 10, 1'b0);
    drive_seg(1'b1, 15, 1'b0);
    enable = 1'b0;
    drive_seg(1'b1, 10, 1'b0);
    check("disable_busy", int'(busy), 0);
    check("disable_det_en", int'(envelop_detector_enable), 0);
    enable = 1'b1;
    model_reset();
    send(1'b1, 10, 1'b0);
    send(1'b0, 30, 1'b0);
    send_bits(32'h96, 8, 1'b0);
    send(1'b1, 150, 1'b0);
    wait_drain("drain_after_disable");

    // Reset mid-byte
    drive_seg(1'b0, 30, 1'b0);
    drive_seg(1'b1, 35, 1'b0);
    drive_seg(1'b0, 10, 1'b0);
    drive_seg(1'b1, 12, 1'b0);
    reset = 1'b0;
    drive_seg(1'b1, 5, 1'b0);
    check_reset_outputs("midreset");
    reset = 1'b1;
    model_reset();
    send(1'b1, 10, 1'b0);
    send(1'b0, 30, 1'b0);
    send_bits(32'h5A, 8, 1'b0);
    send(1'b1, 150, 1'b0);
    wait_drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
